// File: rtl/fetch_2.sv
// fetch_2: two-line (even/odd) fetch buffer that presents a 16-byte decode window starting at the current byte.
// Latency: a line usable in cycle N is latched at the edge and appears in the window from cycle N+1.
// Backpressure: a latch accepts a line only when it is empty (or on a redirect); decode consumes only from a full window.
// Ports: clk/reset (async, active-high); line_*_in, cache_miss_*_in, *W_in, fault_*_in from fetch_1;
//        is_CF_in/target_off_in/target_par_in redirect; consume_in/consume_len_in from decode;
//        *_latch_was_loaded back to fetch_1; window_out/window_valid/window_fault to decode.
module fetch_2 (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] line_even_in,
    input  logic [127:0] line_odd_in,
    input  logic         cache_miss_even_in,
    input  logic         cache_miss_odd_in,
    input  logic         evenW_in,
    input  logic         oddW_in,
    input  logic         fault_even_in,
    input  logic         fault_odd_in,
    input  logic         is_CF_in,
    input  logic [3:0]   target_off_in,
    input  logic         target_par_in,
    input  logic         consume_in,
    input  logic [3:0]   consume_len_in,
    output logic         even_latch_was_loaded,
    output logic         odd_latch_was_loaded,
    output logic [127:0] window_out,
    output logic         window_valid,
    output logic         window_fault
);

    logic [127:0] even_dat_q, even_dat_d, odd_dat_q, odd_dat_d;
    logic         even_vld_q, even_vld_d, odd_vld_q, odd_vld_d;
    logic         even_flt_q, even_flt_d, odd_flt_q, odd_flt_d;
    logic         cur_par_q, cur_par_d;
    logic [3:0]   off_q, off_d;

    logic         even_usable, odd_usable;
    logic         even_load, odd_load;
    logic         consume_ok;
    logic [4:0]   sum;
    logic [127:0] cur_dat, nxt_dat;
    logic [255:0] cat, shifted;

    assign even_usable = ~cache_miss_even_in & ~evenW_in;
    assign odd_usable  = ~cache_miss_odd_in  & ~oddW_in;

    // A redirect empties both latches, so the target lines fetch_1 presents
    // this same cycle are taken regardless of the latches' prior state.
    assign even_load = even_usable & (is_CF_in | ~even_vld_q);
    assign odd_load  = odd_usable  & (is_CF_in | ~odd_vld_q);

    assign even_latch_was_loaded = even_load & ~reset;
    assign odd_latch_was_loaded  = odd_load  & ~reset;

    assign window_valid = even_vld_q & odd_vld_q;
    assign consume_ok   = consume_in & window_valid & (consume_len_in != 4'd0) & ~is_CF_in;
    assign sum          = {1'b0, off_q} + {1'b0, consume_len_in};

    always_comb begin
        even_dat_d = even_dat_q;
        odd_dat_d  = odd_dat_q;
        even_vld_d = even_vld_q;
        odd_vld_d  = odd_vld_q;
        even_flt_d = even_flt_q;
        odd_flt_d  = odd_flt_q;
        cur_par_d  = cur_par_q;
        off_d      = off_q;

        if (is_CF_in) begin
            even_vld_d = 1'b0;
            odd_vld_d  = 1'b0;
            even_flt_d = 1'b0;
            odd_flt_d  = 1'b0;
            off_d      = target_off_in;
            cur_par_d  = target_par_in;
        end else if (consume_ok) begin
            off_d = sum[3:0];
            // Walking past the end of the current line retires it; the
            // other latch becomes current.
            if (sum[4]) begin
                cur_par_d = ~cur_par_q;
                if (cur_par_q) begin
                    odd_vld_d = 1'b0;
                    odd_flt_d = 1'b0;
                end else begin
                    even_vld_d = 1'b0;
                    even_flt_d = 1'b0;
                end
            end
        end

        // Loads cannot collide with a retire: consume needs both latches
        // full, and a load only happens into an empty latch (or on redirect).
        if (even_load) begin
            even_vld_d = 1'b1;
            even_dat_d = line_even_in;
            even_flt_d = fault_even_in;
        end
        if (odd_load) begin
            odd_vld_d = 1'b1;
            odd_dat_d = line_odd_in;
            odd_flt_d = fault_odd_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            even_dat_q <= '0;
            odd_dat_q  <= '0;
            even_vld_q <= 1'b0;
            odd_vld_q  <= 1'b0;
            even_flt_q <= 1'b0;
            odd_flt_q  <= 1'b0;
            cur_par_q  <= 1'b0;
            off_q      <= 4'd0;
        end else begin
            even_dat_q <= even_dat_d;
            odd_dat_q  <= odd_dat_d;
            even_vld_q <= even_vld_d;
            odd_vld_q  <= odd_vld_d;
            even_flt_q <= even_flt_d;
            odd_flt_q  <= odd_flt_d;
            cur_par_q  <= cur_par_d;
            off_q      <= off_d;
        end
    end

    // Window is built from registered state only: current line in the low
    // half, following line above it, then byte-shifted by the offset.
    assign cur_dat = cur_par_q ? odd_dat_q  : even_dat_q;
    assign nxt_dat = cur_par_q ? even_dat_q : odd_dat_q;
    assign cat     = {nxt_dat, cur_dat};
    assign shifted = cat >> {off_q, 3'b000};

    assign window_out = window_valid ? shifted[127:0] : 128'd0;
    // With both latches valid, they are exactly the current and next line.
    assign window_fault = window_valid & (even_flt_q | odd_flt_q);

endmodule

// File: tb/tb_fetch_2.sv
// tb_fetch_2: directed scenarios followed by randomized traffic, checked against a byte-level reference model.
// Latency: model state advances on each rising edge; outputs are compared mid-cycle.
// Backpressure: bench drives miss/W and consume freely; the model decides what is accepted.
module tb_fetch_2;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] line_even_in, line_odd_in;
    logic         cache_miss_even_in, cache_miss_odd_in, evenW_in, oddW_in;
    logic         fault_even_in, fault_odd_in;
    logic         is_CF_in;
    logic [3:0]   target_off_in;
    logic         target_par_in;
    logic         consume_in;
    logic [3:0]   consume_len_in;
    logic         even_latch_was_loaded, odd_latch_was_loaded;
    logic [127:0] window_out;
    logic         window_valid, window_fault;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: bytes per latch, index 0 = even, 1 = odd.
    logic [7:0] m_dat [0:1][0:15];
    bit         m_vld [0:1];
    bit         m_flt [0:1];
    int         m_par;
    int         m_off;

    always #5 clk = ~clk;

    fetch_2 dut (
        .clk                   (clk),
        .reset                 (reset),
        .line_even_in          (line_even_in),
        .line_odd_in           (line_odd_in),
        .cache_miss_even_in    (cache_miss_even_in),
        .cache_miss_odd_in     (cache_miss_odd_in),
        .evenW_in              (evenW_in),
        .oddW_in               (oddW_in),
        .fault_even_in         (fault_even_in),
        .fault_odd_in          (fault_odd_in),
        .is_CF_in              (is_CF_in),
        .target_off_in         (target_off_in),
        .target_par_in         (target_par_in),
        .consume_in            (consume_in),
        .consume_len_in        (consume_len_in),
        .even_latch_was_loaded (even_latch_was_loaded),
        .odd_latch_was_loaded  (odd_latch_was_loaded),
        .window_out            (window_out),
        .window_valid          (window_valid),
        .window_fault          (window_fault)
    );

    function automatic logic [127:0] mkline(input logic [7:0] base);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = base + 8'(i);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit usable(input int b);
        if (b == 0) return !cache_miss_even_in && !evenW_in;
        return !cache_miss_odd_in && !oddW_in;
    endfunction

    function automatic bit exp_loaded(input int b);
        if (reset) return 1'b0;
        return usable(b) && (is_CF_in || !m_vld[b]);
    endfunction

    function automatic logic [127:0] exp_window();
        logic [127:0] w = '0;
        if (!(m_vld[0] && m_vld[1])) return w;
        for (int i = 0; i < 16; i++) begin
            int idx = m_off + i;
            if (idx < 16) w[8*i +: 8] = m_dat[m_par][idx];
            else          w[8*i +: 8] = m_dat[1 - m_par][idx - 16];
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_vld[b] = 0;
            m_flt[b] = 0;
            for (int i = 0; i < 16; i++) m_dat[b][i] = 8'h00;
        end
        m_par = 0;
        m_off = 0;
    endtask

    task automatic model_load(input int b);
        logic [127:0] l;
        l = (b == 0) ? line_even_in : line_odd_in;
        for (int i = 0; i < 16; i++) m_dat[b][i] = l[8*i +: 8];
        m_flt[b] = (b == 0) ? fault_even_in : fault_odd_in;
        m_vld[b] = 1;
    endtask

    task automatic model_edge();
        bit full;
        bit ld [0:1];
        if (reset) begin
            model_reset();
            return;
        end
        full = m_vld[0] && m_vld[1];
        for (int b = 0; b < 2; b++) ld[b] = usable(b) && (is_CF_in || !m_vld[b]);
        if (is_CF_in) begin
            m_vld[0] = 0;
            m_vld[1] = 0;
            m_off = int'(target_off_in);
            m_par = int'(target_par_in);
        end else if (consume_in && full && consume_len_in != 0) begin
            m_off = m_off + int'(consume_len_in);
            if (m_off >= 16) begin
                m_off -= 16;
                m_vld[m_par] = 0;
                m_par = 1 - m_par;
            end
        end
        for (int b = 0; b < 2; b++) if (ld[b]) model_load(b);
    endtask

    task automatic check_all();
        chk("even_was_loaded", 128'(even_latch_was_loaded), 128'(exp_loaded(0)));
        chk("odd_was_loaded",  128'(odd_latch_was_loaded),  128'(exp_loaded(1)));
        chk("window_valid",    128'(window_valid),          128'(m_vld[0] && m_vld[1]));
        chk("window_out",      window_out,                  exp_window());
        chk("window_fault",    128'(window_fault),
            128'(m_vld[0] && m_vld[1] && (m_flt[0] || m_flt[1])));
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        line_even_in = '0; line_odd_in = '0;
        cache_miss_even_in = 0; cache_miss_odd_in = 0; evenW_in = 0; oddW_in = 0;
        fault_even_in = 0; fault_odd_in = 0;
        is_CF_in = 0; target_off_in = 0; target_par_in = 0;
        consume_in = 0; consume_len_in = 0;
        model_reset();

        // Reset state: banks usable but was_loaded must stay low.
        @(negedge clk);
        #1;
        chk("rst_even_wl", 128'(even_latch_was_loaded), 128'd0);
        chk("rst_window_valid", 128'(window_valid), 128'd0);
        chk("rst_window_out", window_out, 128'd0);
        tick();

        // First fill.
        reset = 1'b0;
        line_even_in = mkline(8'h00);
        line_odd_in  = mkline(8'h10);
        #1;
        chk("fill_even_wl", 128'(even_latch_was_loaded), 128'd1);
        chk("fill_odd_wl",  128'(odd_latch_was_loaded),  128'd1);
        tick();
        chk("fill_window", window_out, mkline(8'h00));
        chk("fill_valid", 128'(window_valid), 128'd1);

        // Consume 6 then 12 (crosses into odd line).
        cache_miss_even_in = 1; cache_miss_odd_in = 1;
        consume_in = 1; consume_len_in = 4'd6;
        tick();
        chk("consume6_window", window_out, mkline(8'h06));
        consume_len_in = 4'd12;
        tick();
        chk("cross_valid", 128'(window_valid), 128'd0);
        consume_in = 0;
        cache_miss_even_in = 0;
        line_even_in = mkline(8'h20);
        #1;
        chk("refill_even_wl", 128'(even_latch_was_loaded), 128'd1);
        tick();
        chk("refill_window", window_out, mkline(8'h12));

        // Redirect with even bank missing.
        is_CF_in = 1; target_off_in = 4'hD; target_par_in = 1;
        cache_miss_even_in = 1; cache_miss_odd_in = 0;
        line_odd_in = mkline(8'h40);
        #1;
        chk("cf_odd_wl",  128'(odd_latch_was_loaded),  128'd1);
        chk("cf_even_wl", 128'(even_latch_was_loaded), 128'd0);
        tick();
        is_CF_in = 0; cache_miss_odd_in = 1;
        tick();
        chk("cf_wait_valid", 128'(window_valid), 128'd0);
        tick();
        cache_miss_even_in = 0;
        line_even_in = mkline(8'h50);
        tick();
        chk("cf_window", window_out, mkline(8'h4D));
        cache_miss_even_in = 1;

        // Redirect and consume together: consume ignored.
        is_CF_in = 1; consume_in = 1; consume_len_in = 4'd3;
        target_off_in = 4'd5; target_par_in = 0;
        cache_miss_even_in = 0; cache_miss_odd_in = 0;
        line_even_in = mkline(8'h60); line_odd_in = mkline(8'h70);
        tick();
        is_CF_in = 0; consume_in = 0;
        cache_miss_even_in = 1; cache_miss_odd_in = 1;
        chk("cf_consume_window", window_out, mkline(8'h65));

        // Faulting odd line, then retire it behind clean lines.
        is_CF_in = 1; target_off_in = 0; target_par_in = 0;
        cache_miss_even_in = 0; cache_miss_odd_in = 0;
        fault_odd_in = 1;
        line_even_in = mkline(8'h80); line_odd_in = mkline(8'h90);
        tick();
        is_CF_in = 0; fault_odd_in = 0;
        cache_miss_even_in = 1; cache_miss_odd_in = 1;
        chk("fault_set", 128'(window_fault), 128'd1);
        consume_in = 1; consume_len_in = 4'd15; tick();
        consume_len_in = 4'd1; tick();
        chk("fault_gap_valid", 128'(window_valid), 128'd0);
        consume_in = 0; cache_miss_even_in = 0; line_even_in = mkline(8'hA0); tick();
        cache_miss_even_in = 1;
        chk("fault_still", 128'(window_fault), 128'd1);
        consume_in = 1; consume_len_in = 4'd15; tick();
        consume_len_in = 4'd1; tick();
        consume_in = 0; cache_miss_odd_in = 0; line_odd_in = mkline(8'hB0); tick();
        cache_miss_odd_in = 1;
        chk("fault_cleared", 128'(window_fault), 128'd0);
        chk("fault_cleared_valid", 128'(window_valid), 128'd1);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_valid", 128'(window_valid), 128'd0);
        chk("async_rst_window", window_out, 128'd0);
        tick();
        reset = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            reset              = ($urandom_range(0, 96) == 0);
            if (reset) model_reset();
            line_even_in       = {$urandom, $urandom, $urandom, $urandom};
            line_odd_in        = {$urandom, $urandom, $urandom, $urandom};
            cache_miss_even_in = ($urandom_range(0, 3) == 0);
            cache_miss_odd_in  = ($urandom_range(0, 3) == 0);
            evenW_in           = ($urandom_range(0, 7) == 0);
            oddW_in            = ($urandom_range(0, 7) == 0);
            fault_even_in      = ($urandom_range(0, 7) == 0);
            fault_odd_in       = ($urandom_range(0, 7) == 0);
            is_CF_in           = ($urandom_range(0, 15) == 0);
            target_off_in      = 4'($urandom_range(0, 15));
            target_par_in      = 1'($urandom_range(0, 1));
            consume_in         = 1'($urandom_range(0, 1));
            consume_len_in     = 4'($urandom_range(0, 15));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_2.md
FETCH_2 -- requirements
Module: fetch_2

Interface
REQ-001 SHALL have ports: clk  in  1  core clock; reset  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
REQ-002 SHALL have: line_even_in, line_odd_in  in  128 each  line data from fetch_1 I$, byte 0 = bits [7:0].
REQ-003 SHALL have: cache_miss_even_in, cache_miss_odd_in, evenW_in, oddW_in  in  1 each  bank line not usable when high.
REQ-004 SHALL have: fault_even_in, fault_odd_in  in  1 each  TLB miss OR protection exception for that bank.
REQ-005 SHALL have: is_CF_in  in  1  control-flow redirect this cycle; target_off_in  in  4  byte offset in target line; target_par_in  in  1  target line-index bit 0 (1 = odd).
REQ-006 SHALL have: consume_in  in  1  decode accepts bytes; consume_len_in  in  4  bytes consumed, 1..15.
REQ-007 SHALL have: even_latch_was_loaded, odd_latch_was_loaded  out  1 each  to fetch_1 FIP register load.
REQ-008 SHALL have: window_out  out  128  16 bytes starting at current byte; window_valid  out  1; window_fault  out  1.

Function
REQ-009 SHALL hold two 128-bit latches (even, odd), each with valid and fault bits, plus state cur_par (1 bit, latch holding current line) and off (4 bits, byte offset in current line).
REQ-010 Bank usable = NOT miss AND NOT W for that bank.
REQ-011 Each latch invalid at cycle start with bank usable SHALL load line and fault at the clock edge; its *_latch_was_loaded SHALL be high that cycle (combinational), else low.
REQ-012 A valid latch SHALL never load; was_loaded low for it.
REQ-013 window_valid = both latches valid; window_out = bytes off..off+15 of {next latch, current latch} (current = low 16 bytes), i.e. 256-bit concat shifted right 8*off, low 128 bits; 0 when not valid.
REQ-014 window_fault = window_valid AND (fault_cur OR fault_next).
REQ-015 consume_in SHALL be ignored when window_valid low or consume_len_in = 0.
REQ-016 Accepted consume: sum = off + len (5-bit); sum < 16 -> off = sum; sum >= 16 -> off = sum - 16, current latch invalidated, cur_par toggled.
REQ-017 is_CF_in SHALL take priority over consume: both latches invalidated, off = target_off_in, cur_par = target_par_in; in the same cycle each usable bank SHALL still load (and pulse was_loaded) since fetch_1 presents target lines that cycle.
REQ-018 Loads and consumes never collide: consume requires both valid; a latch freed by consume loads no earlier than next cycle.
REQ-019 Latency: line usable in cycle N -> contributes to window_valid in N+1.
REQ-020 window and fault outputs SHALL be combinational from registered state only (no input-to-window path).

Reset
REQ-021 While reset high: both valid and fault bits 0, latch data 0, off = 0, cur_par = 0, window_valid = 0, window_out = 0, window_fault = 0; was_loaded outputs 0 regardless of inputs.
REQ-022 Reset asserted mid-operation SHALL discard buffered lines immediately (asynchronous); first edge after release behaves as REQ-011.

Verification
REQ-023 Reset, both banks usable with even = 16'h00..0F bytes, odd = 10..1F -> both was_loaded high cycle 0; cycle 1 window_valid = 1, window_out bytes 00..0F.
REQ-024 From REQ-023 state, consume len 6 -> off = 6, window bytes 06..15; then len 12 -> sum 18, off = 2, cur_par = 1, even invalid, window_valid = 0, next cycle even_latch_was_loaded high if usable.
REQ-025 is_CF_in with target_off_in = 4'hD, target_par_in = 1, odd usable, even miss -> odd loads, even_latch_was_loaded low, window_valid stays 0 until even usable; then window bytes odd[13..15], even[0..12].
REQ-026 is_CF_in and consume_in same cycle -> consume ignored, off = target_off_in.
REQ-027 fault_odd_in = 1 on load, both valid -> window_fault = 1; consume crossing out of odd line clears it once faultless lines fill.
REQ-028 Reset asserted between edges while both valid -> window_valid drops to 0 without waiting for clk.
